// File: rtl/core_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package core_imem_loader_pkg;

  // Byte-address shift between consecutive 64-bit image words.
  localparam int WORD_SHIFT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } load_state_e;

endpackage

// File: rtl/core_imem_loader.sv
// Streams a program image into the core's instruction memory while holding the core in reset,
// then releases the core after a fixed settling delay.
module core_imem_loader
  import core_imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int IMEM_SIZE_BYTES = 8192,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [ADDR_WIDTH-1:0]   load_base_addr,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH/8-1:0] ins_dma_wen,
  output logic [ADDR_WIDTH-1:0]   ins_dma_addr,
  output logic [DATA_WIDTH-1:0]   ins_dma_wr_data,
  output logic                    core_reset,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ADDR_WIDTH-1:0]   word_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(1) << WORD_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(WORD_BYTES - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH:0]   IMEM_LIMIT = (ADDR_WIDTH + 1)'(IMEM_SIZE_BYTES);
  localparam logic [HOLD_W-1:0]     HOLD_INIT  = HOLD_W'(HOLD_CYCLES);

  load_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
  logic                      ptr_wrap_q, ptr_wrap_d;
  logic [ADDR_WIDTH-1:0]     word_count_q, word_count_d;
  logic                      load_err_q, load_err_d;
  logic                      core_reset_q, core_reset_d;
  logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic [KEEP_W-1:0]         wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      done_q, done_d;
  logic                      tready_q, tready_d;
  logic                      busy_q, busy_d;

  logic                      hs;
  logic                      in_range;
  logic [ADDR_WIDTH:0]       ptr_sum;

  assign hs       = s_tvalid & tready_q;
  assign ptr_sum  = {1'b0, ptr_q} + {1'b0, WORD_BYTES};
  // The wrap bit keeps a pointer that rolled past 2^ADDR_WIDTH out of range.
  assign in_range = {ptr_wrap_q, ptr_q} < IMEM_LIMIT;

  // Next-state, pointer bookkeeping and write-stage computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ptr_wrap_d   = ptr_wrap_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    core_reset_d = core_reset_q;
    hold_cnt_d   = hold_cnt_q;
    wen_d        = '0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d      = S_LOAD;
          ptr_d        = load_base_addr & ALIGN_MASK;
          ptr_wrap_d   = 1'b0;
          word_count_d = '0;
          load_err_d   = 1'b0;
          core_reset_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (hs && in_range) begin
          wen_d        = s_tkeep;
          addr_d       = ptr_q;
          wdata_d      = s_tdata;
          ptr_d        = ptr_sum[ADDR_WIDTH-1:0];
          ptr_wrap_d   = ptr_wrap_q | ptr_sum[ADDR_WIDTH];
          word_count_d = word_count_q + ADDR_WIDTH'(1);
          if (s_tlast) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = S_LOAD;
          end
        end else if (hs) begin
          load_err_d = 1'b1;
          if (s_tlast) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (hs && s_tlast) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d      = S_IDLE;
          core_reset_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tready_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; the core stays in reset until a load completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      ptr_wrap_q   <= 1'b0;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
      core_reset_q <= 1'b1;
      hold_cnt_q   <= '0;
      wen_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      tready_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ptr_wrap_q   <= ptr_wrap_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
      core_reset_q <= core_reset_d;
      hold_cnt_q   <= hold_cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      tready_q     <= tready_d;
      busy_q       <= busy_d;
    end
  end

  assign s_tready        = tready_q;
  assign ins_dma_wen     = wen_q;
  assign ins_dma_addr    = addr_q;
  assign ins_dma_wr_data = wdata_q;
  assign core_reset      = core_reset_q;
  assign load_busy       = busy_q;
  assign load_done       = done_q;
  assign load_err        = load_err_q;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_core_imem_loader.sv
// Directed bench for core_imem_loader: nominal, unaligned, backpressure, overflow and disturbances.
module tb_core_imem_loader;
  import core_imem_loader_pkg::*;

  localparam int DW = 64;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_base_addr;
  logic [DW-1:0] s_tdata;
  logic [7:0]    s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [7:0]    ins_dma_wen;
  logic [AW-1:0] ins_dma_addr;
  logic [DW-1:0] ins_dma_wr_data;
  logic          core_reset;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW-1:0] word_count;

  int checks = 0;
  int failures = 0;
  int nwrites = 0;
  int w0;

  core_imem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base_addr(load_base_addr),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .ins_dma_wen(ins_dma_wen), .ins_dma_addr(ins_dma_addr),
    .ins_dma_wr_data(ins_dma_wr_data), .core_reset(core_reset), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ins_dma_wen != 8'h00) nwrites <= nwrites + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    load_base_addr = base;
    load_start     = 1'b1;
    tick();
    load_start     = 1'b0;
    check_eq("start_busy", load_busy, 1);
    check_eq("start_core_reset", core_reset, 1);
    check_eq("start_word_count", word_count, 0);
    check_eq("start_err_cleared", load_err, 0);
    check_eq("start_tready", s_tready, 1);
  endtask

  task automatic send_word(input logic [63:0] data, input logic [7:0] keep, input logic last,
                           input logic [AW-1:0] exp_addr, input logic [7:0] exp_wen);
    bit got = 1'b0;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = s_tready;
    end
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_eq("handshake_seen", got, 1);
    check_eq("wr_wen", ins_dma_wen, exp_wen);
    if (exp_wen != 8'h00) begin
      check_eq("wr_addr", ins_dma_addr, exp_addr);
      check_eq("wr_data", ins_dma_wr_data, data);
    end
  endtask

  task automatic wait_done(input bit poke_start);
    int n = 0;
    bit seen = 1'b0;
    check_eq("in_hold", dut.state_q, S_HOLD);
    check_eq("held_in_hold", core_reset, 1);
    while (!seen && n < 40) begin
      if (poke_start && n == 16) begin
        load_start     = 1'b1;
        load_base_addr = 16'h0800;
      end
      tick();
      n++;
      seen = load_done;
    end
    load_start = 1'b0;
    check_eq("done_latency", n, 17);
    check_eq("core_released", core_reset, 0);
    check_eq("idle_on_done", load_busy, 0);
    tick();
    check_eq("done_pulse_width", load_done, 0);
    check_eq("stay_idle", load_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_base_addr = 16'h0000;
    s_tdata = 64'h0; s_tkeep = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    tick();
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_tready", s_tready, 0);
    check_eq("rst_wen", ins_dma_wen, 0);
    check_eq("rst_done", load_done, 0);
    check_eq("rst_busy", load_busy, 0);
    check_eq("rst_err", load_err, 0);
    check_eq("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_tready", s_tready, 0);

    // Nominal four-word load; a load_start on the release cycle must be ignored.
    start_load(16'h0000);
    send_word(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 16'h0000, 8'hFF);
    send_word(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 16'h0008, 8'hFF);
    send_word(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b0, 16'h0010, 8'hFF);
    send_word(64'hDDDD_EEEE_FFFF_0001, 8'hFF, 1'b1, 16'h0018, 8'hFF);
    check_eq("nominal_word_count", word_count, 4);
    wait_done(1'b1);

    start_load(16'h0105);
    send_word(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 16'h0100, 8'hFF);
    send_word(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 16'h0108, 8'hFF);
    wait_done(1'b0);
    check_eq("unaligned_word_count", word_count, 2);

    // s_tvalid pattern 1,0,0,1,1.
    start_load(16'h0200);
    w0 = nwrites;
    send_word(64'hA000_0000_0000_0001, 8'hFF, 1'b0, 16'h0200, 8'hFF);
    tick();
    check_eq("gap1_wen", ins_dma_wen, 0);
    tick();
    check_eq("gap2_wen", ins_dma_wen, 0);
    send_word(64'hA000_0000_0000_0002, 8'h0F, 1'b0, 16'h0208, 8'h0F);
    send_word(64'hA000_0000_0000_0003, 8'hFF, 1'b1, 16'h0210, 8'hFF);
    wait_done(1'b0);
    check_eq("bp_write_count", nwrites - w0, 3);

    // Empty keep still advances pointer and count.
    start_load(16'h0040);
    send_word(64'hB000_0000_0000_0001, 8'h00, 1'b0, 16'h0040, 8'h00);
    send_word(64'hB000_0000_0000_0002, 8'hFF, 1'b1, 16'h0048, 8'hFF);
    wait_done(1'b0);
    check_eq("keep0_word_count", word_count, 2);

    start_load(16'h1FF8);
    send_word(64'hC000_0000_0000_0001, 8'hFF, 1'b0, 16'h1FF8, 8'hFF);
    send_word(64'hC000_0000_0000_0002, 8'hFF, 1'b0, 16'h0000, 8'h00);
    check_eq("ovf_err", load_err, 1);
    check_eq("ovf_drain", dut.state_q, S_DRAIN);
    check_eq("ovf_drain_tready", s_tready, 1);
    send_word(64'hC000_0000_0000_0003, 8'hFF, 1'b1, 16'h0000, 8'h00);
    wait_done(1'b0);
    check_eq("ovf_word_count", word_count, 1);
    check_eq("ovf_err_sticky", load_err, 1);

    start_load(16'h0300);
    send_word(64'hD000_0000_0000_0001, 8'hFF, 1'b0, 16'h0300, 8'hFF);
    load_base_addr = 16'h0900;
    load_start     = 1'b1;
    tick();
    load_start     = 1'b0;
    check_eq("busy_start_state", dut.state_q, S_LOAD);
    check_eq("busy_start_word_count", word_count, 1);
    send_word(64'hD000_0000_0000_0002, 8'hFF, 1'b1, 16'h0308, 8'hFF);
    wait_done(1'b0);
    check_eq("busy_word_count", word_count, 2);

    // Reset in the middle of a load while a word is being offered.
    start_load(16'h0400);
    send_word(64'hE000_0000_0000_0001, 8'hFF, 1'b0, 16'h0400, 8'hFF);
    s_tdata  = 64'hE000_0000_0000_0002;
    s_tkeep  = 8'hFF;
    s_tvalid = 1'b1;
    rst_n    = 1'b0;
    tick();
    check_eq("midrst_wen", ins_dma_wen, 0);
    check_eq("midrst_core_reset", core_reset, 1);
    check_eq("midrst_state", dut.state_q, S_IDLE);
    check_eq("midrst_busy", load_busy, 0);
    check_eq("midrst_tready", s_tready, 0);
    check_eq("midrst_word_count", word_count, 0);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check_eq("postrst_wen", ins_dma_wen, 0);
    start_load(16'h0500);
    send_word(64'hF000_0000_0000_0001, 8'hFF, 1'b1, 16'h0500, 8'hFF);
    wait_done(1'b0);
    check_eq("postrst_word_count", word_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
